// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running pixel/line counters decoded into
// registered coordinates, sync pulses, display enable and line/frame strobes.
module vga_timing_gen #(
  parameter int   H_VIS  = 1440,
  parameter int   H_FP   = 80,
  parameter int   H_SYNC = 152,
  parameter int   H_BP   = 232,
  parameter int   V_VIS  = 900,
  parameter int   V_FP   = 1,
  parameter int   V_SYNC = 3,
  parameter int   V_BP   = 28,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b1,
  parameter int   CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_VIS + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_VIS + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          h_wrap;

  logic [CW-1:0] hcount_q, vcount_q;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [7:0]    frame_count_q, frame_count_d;

  // Counter stage: v only moves on the h wrap, so every output decoded from
  // v (vsync included) changes on the same edge that hcount returns to 0.
  always_comb begin
    h_wrap = (int'(h_q) == H_TOTAL - 1);
    h_d    = h_wrap ? '0 : h_q + CW'(1);
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (int'(v_q) == V_TOTAL - 1) ? '0 : v_q + CW'(1);
    end
  end

  // Decode stage: everything below sees the same (h_q, v_q) pair.
  always_comb begin
    de_d          = (int'(h_q) < H_VIS) && (int'(v_q) < V_VIS);
    hsync_d       = ((int'(h_q) >= HS_BEG) && (int'(h_q) < HS_END)) ? H_POL : ~H_POL;
    vsync_d       = ((int'(v_q) >= VS_BEG) && (int'(v_q) < VS_END)) ? V_POL : ~V_POL;
    line_start_d  = (h_q == '0);
    frame_start_d = line_start_d && (v_q == '0);
    frame_count_d = frame_count_q + {7'd0, frame_start_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hcount_q      <= h_q;
      vcount_q      <= v_q;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 1440x900 instance and a tiny override
// instance, both compared cycle by cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;

  logic [10:0] a_hcount, a_vcount, b_hcount, b_vcount;
  logic        a_hsync, a_vsync, a_de, a_line_start, a_frame_start;
  logic        b_hsync, b_vsync, b_de, b_line_start, b_frame_start;
  logic [7:0]  a_frame_count, b_frame_count;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int ta  = 0;
  int tbt = 0;

  localparam logic [34:0] RST_A = {11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
  localparam logic [34:0] RST_B = {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a),
    .hcount(a_hcount), .vcount(a_vcount), .hsync(a_hsync), .vsync(a_vsync),
    .de(a_de), .line_start(a_line_start), .frame_start(a_frame_start),
    .frame_count(a_frame_count)
  );

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(11)
  ) u_dut_b (
    .clk(clk), .rst(rst_b),
    .hcount(b_hcount), .vcount(b_vcount), .hsync(b_hsync), .vsync(b_vsync),
    .de(b_de), .line_start(b_line_start), .frame_start(b_frame_start),
    .frame_count(b_frame_count)
  );

  // Output expected t cycles after the first edge with reset released.
  function automatic logic [34:0] model(input int t, input int hv, hfp, hs, hbp,
                                        input int vv, vfp, vs, vbp,
                                        input logic hp, vp);
    int ht, vt, ft, p, h, v, fc;
    logic hsy, vsy, den, ls, fs;
    ht  = hv + hfp + hs + hbp;
    vt  = vv + vfp + vs + vbp;
    ft  = ht * vt;
    p   = t % ft;
    h   = p % ht;
    v   = p / ht;
    fc  = (t / ft + 1) % 256;
    den = (h < hv) && (v < vv);
    hsy = (h >= hv + hfp && h < hv + hfp + hs) ? hp : ~hp;
    vsy = (v >= vv + vfp && v < vv + vfp + vs) ? vp : ~vp;
    ls  = (h == 0);
    fs  = ls && (v == 0);
    return {h[10:0], v[10:0], hsy, vsy, den, ls, fs, fc[7:0]};
  endfunction

  function automatic logic [34:0] model_a(input int t);
    return model(t, 1440, 80, 152, 232, 900, 1, 3, 28, 1'b0, 1'b1);
  endfunction

  function automatic logic [34:0] model_b(input int t);
    return model(t, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1);
  endfunction

  function automatic logic [34:0] obs_a();
    return {a_hcount, a_vcount, a_hsync, a_vsync, a_de, a_line_start, a_frame_start, a_frame_count};
  endfunction

  function automatic logic [34:0] obs_b();
    return {b_hcount, b_vcount, b_hsync, b_vsync, b_de, b_line_start, b_frame_start, b_frame_count};
  endfunction

  task automatic test_reset_a();
    int n;
    n = $urandom_range(9, 5);
    rst_a = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cnt++;
      if (obs_a() !== RST_A) $display("FAIL reset_hold_a: got %h expected %h", obs_a(), RST_A);
      else pass_cnt++;
    end
    rst_a = 1'b0;
    @(negedge clk);
    ta = 0;
    check_cnt++;
    if ({a_hcount, a_vcount, a_de, a_line_start, a_frame_start, a_frame_count, a_hsync, a_vsync}
        !== {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0})
      $display("FAIL release_first_a: got %h expected hc=0 vc=0 de=1 ls=1 fs=1 fc=1 hs=1 vs=0", obs_a());
    else pass_cnt++;
  endtask

  task automatic test_horizontal_a();
    int de_cnt, hs_cnt, hs_first, hs_last, last_ls;
    logic [10:0] prev_h, prev_v;
    de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; last_ls = 0;
    prev_h = a_hcount; prev_v = a_vcount;
    while (ta < 3 * 1904) begin
      @(negedge clk);
      ta++;
      check_cnt++;
      if (obs_a() !== model_a(ta)) $display("FAIL model_a t=%0d: got %h expected %h", ta, obs_a(), model_a(ta));
      else pass_cnt++;
      if (a_vcount == 11'd1) begin
        if (a_de) de_cnt++;
        if (!a_hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(a_hcount);
          hs_last = int'(a_hcount);
        end
      end
      if (a_line_start) begin
        check_cnt++;
        if (ta - last_ls !== 1904) $display("FAIL line_period_a: got %0d expected 1904", ta - last_ls);
        else pass_cnt++;
        last_ls = ta;
      end
      if (prev_h == 11'd1903) begin
        check_cnt++;
        if ({a_hcount, a_vcount} !== {11'd0, prev_v + 11'd1})
          $display("FAIL line_wrap_a: got hc=%0d vc=%0d expected hc=0 vc=%0d", a_hcount, a_vcount, prev_v + 11'd1);
        else pass_cnt++;
      end
      prev_h = a_hcount; prev_v = a_vcount;
    end
    check_cnt++;
    if (de_cnt !== 1440) $display("FAIL de_width_a: got %0d expected 1440", de_cnt);
    else pass_cnt++;
    check_cnt++;
    if ({hs_cnt, hs_first, hs_last} !== {32'd152, 32'd1520, 32'd1671})
      $display("FAIL hsync_window_a: got cnt=%0d first=%0d last=%0d expected 152 1520 1671", hs_cnt, hs_first, hs_last);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset_a();
    int n;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(2500, 300);
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        ta++;
        check_cnt++;
        if (obs_a() !== model_a(ta)) $display("FAIL model_a t=%0d: got %h expected %h", ta, obs_a(), model_a(ta));
        else pass_cnt++;
      end
      rst_a = 1'b1;
      @(negedge clk);
      check_cnt++;
      if (obs_a() !== RST_A) $display("FAIL midreset_a: got %h expected %h", obs_a(), RST_A);
      else pass_cnt++;
      rst_a = 1'b0;
      @(negedge clk);
      ta = 0;
      check_cnt++;
      if ({a_hcount, a_vcount, a_frame_start, a_frame_count} !== {11'd0, 11'd0, 1'b1, 8'd1})
        $display("FAIL midreset_restart_a: got %h expected hc=0 vc=0 fs=1 fc=1", obs_a());
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_b();
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_cnt++;
      if (obs_b() !== RST_B) $display("FAIL reset_hold_b: got %h expected %h", obs_b(), RST_B);
      else pass_cnt++;
    end
    rst_b = 1'b0;
    @(negedge clk);
    tbt = 0;
    check_cnt++;
    if (obs_b() !== model_b(0)) $display("FAIL release_b: got %h expected %h", obs_b(), model_b(0));
    else pass_cnt++;
  endtask

  task automatic test_vertical_b();
    int vs_cnt, hs_cnt;
    logic prev_vs;
    vs_cnt = 0; hs_cnt = 0; prev_vs = b_vsync;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      tbt++;
      check_cnt++;
      if (obs_b() !== model_b(tbt)) $display("FAIL model_b t=%0d: got %h expected %h", tbt, obs_b(), model_b(tbt));
      else pass_cnt++;
      if (b_vsync !== prev_vs) begin
        check_cnt++;
        if (b_hcount !== 11'd0) $display("FAIL vsync_edge_b: got hc=%0d expected 0", b_hcount);
        else pass_cnt++;
      end
      if (b_vsync) begin
        vs_cnt++;
        check_cnt++;
        if (b_vcount < 11'd5 || b_vcount > 11'd6) $display("FAIL vsync_line_b: got vc=%0d expected 5..6", b_vcount);
        else pass_cnt++;
      end
      if (b_vcount >= 11'd4) begin
        check_cnt++;
        if (b_de !== 1'b0) $display("FAIL de_blank_b: got %b expected 0 at vc=%0d", b_de, b_vcount);
        else pass_cnt++;
      end
      if (b_vcount == 11'd2 && b_hsync) begin
        hs_cnt++;
        check_cnt++;
        if (b_hcount < 11'd10 || b_hcount > 11'd12) $display("FAIL hsync_col_b: got hc=%0d expected 10..12", b_hcount);
        else pass_cnt++;
      end
      prev_vs = b_vsync;
    end
    check_cnt++;
    if ({vs_cnt, hs_cnt} !== {32'd64, 32'd6}) $display("FAIL sync_counts_b: got vs=%0d hs=%0d expected 64 6", vs_cnt, hs_cnt);
    else pass_cnt++;
  endtask

  task automatic test_frame_wrap_b();
    int fs_seen, last_fs;
    bit found;
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    tbt = 0; fs_seen = 1; last_fs = 0; found = 0;
    for (int i = 0; i < 300 * 128 && !found; i++) begin
      @(negedge clk);
      tbt++;
      check_cnt++;
      if (obs_b() !== model_b(tbt)) $display("FAIL model_b t=%0d: got %h expected %h", tbt, obs_b(), model_b(tbt));
      else pass_cnt++;
      if (b_frame_start) begin
        fs_seen++;
        check_cnt++;
        if (tbt - last_fs !== 128) $display("FAIL frame_period_b: got %0d expected 128", tbt - last_fs);
        else pass_cnt++;
        last_fs = tbt;
        if (b_frame_count == 8'd0) begin
          found = 1;
          check_cnt++;
          if (fs_seen !== 256) $display("FAIL frame_wrap_b: got wrap at frame %0d expected 256", fs_seen);
          else pass_cnt++;
        end
      end
    end
    if (!found) begin
      check_cnt++;
      $display("FAIL frame_wrap_timeout_b: got no wrap after %0d cycles expected wrap at frame 256", tbt);
    end
  endtask

  task automatic test_mid_reset_b();
    int n, k;
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(200, 1);
      k = $urandom_range(3, 1);
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        tbt++;
        check_cnt++;
        if (obs_b() !== model_b(tbt)) $display("FAIL model_b t=%0d: got %h expected %h", tbt, obs_b(), model_b(tbt));
        else pass_cnt++;
      end
      rst_b = 1'b1;
      for (int i = 0; i < k; i++) begin
        @(negedge clk);
        check_cnt++;
        if (obs_b() !== RST_B) $display("FAIL midreset_b: got %h expected %h", obs_b(), RST_B);
        else pass_cnt++;
      end
      rst_b = 1'b0;
      @(negedge clk);
      tbt = 0;
      check_cnt++;
      if (obs_b() !== model_b(0)) $display("FAIL midreset_restart_b: got %h expected %h", obs_b(), model_b(0));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset_a();
    test_horizontal_a();
    test_mid_reset_a();
    test_reset_b();
    test_vertical_b();
    test_frame_wrap_b();
    test_mid_reset_b();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
